// File: rtl/rx_port_pkg.sv
// Shared types for the RX port packer: DWORD geometry, flush FSM states
// and the FIFO word format (valid-DWORD count alongside the 128-bit data).
package rx_port_pkg;

    localparam int DW_WIDTH     = 32;
    localparam int DWS_PER_WORD = 4;

    typedef enum logic [0:0] {
        S_PACK  = 1'b0,
        S_FLUSH = 1'b1
    } rx_pack_state_t;

    typedef struct packed {
        logic [2:0]   cnt;
        logic [127:0] data;
    } rx_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with a first-word-fall-through head register; the head appears
// one cycle after the first write. Writes are ignored while full; pops while empty are ignored.
module sync_fifo #(
    parameter int C_WIDTH         = 32,
    parameter int C_DEPTH         = 512,
    parameter int C_PROVIDE_COUNT = 1,
    localparam int C_AW = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1,
    localparam int C_CW = $clog2((2**$clog2(C_DEPTH)) + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [C_WIDTH-1:0] wr_dat,
    input  logic               wr_vld,
    output logic               full,
    output logic [C_WIDTH-1:0] rd_dat,
    output logic               empty,
    input  logic               rd_rdy,
    output logic [C_CW-1:0]    count
);

    logic [C_WIDTH-1:0] mem [2**C_AW];
    logic [C_AW-1:0]    wr_ptr;
    logic [C_AW-1:0]    rd_ptr;
    logic [C_CW-1:0]    mem_cnt;
    logic [C_CW-1:0]    cnt_q;
    logic               out_vld;
    logic [C_WIDTH-1:0] out_dat;
    logic               push;
    logic               pop;
    logic               load;

    // cnt_q covers the head register too, so it is the true occupancy.
    assign full  = (cnt_q == C_CW'(C_DEPTH));
    assign push  = wr_vld && !full;
    assign pop   = rd_rdy && out_vld;
    assign load  = (mem_cnt != '0) && (!out_vld || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            cnt_q   <= '0;
            out_vld <= 1'b0;
            out_dat <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + C_AW'(1);
            end
            if (load) begin
                rd_ptr  <= rd_ptr + C_AW'(1);
                out_dat <= mem[rd_ptr];
                out_vld <= 1'b1;
            end else if (pop) begin
                out_vld <= 1'b0;
            end
            mem_cnt <= mem_cnt + C_CW'(push) - C_CW'(load);
            cnt_q   <= cnt_q + C_CW'(push) - C_CW'(pop);
        end
    end

    assign rd_dat = out_dat;
    assign empty  = !out_vld;
    assign count  = (C_PROVIDE_COUNT != 0) ? cnt_q : '0;

endmodule

// File: rtl/rx_port_packer_128.sv
// Packs 1-4 DWORD fragments into 128-bit words, flushing the residue on WR_DONE; head word
// visible 2 cycles after the completing beat. WR_READY drops when fewer than 3 FIFO slots remain.
module rx_port_packer_128
    import rx_port_pkg::*;
#(
    parameter int C_DATA_WIDTH = 128,
    parameter int C_FIFO_DEPTH = 512,
    localparam int C_FIFO_DEPTH_WIDTH = $clog2((2**$clog2(C_FIFO_DEPTH)) + 1)
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [C_DATA_WIDTH-1:0]       WR_DATA,
    input  logic                          WR_EN,
    input  logic [2:0]                    WR_DW_COUNT,
    input  logic                          WR_DONE,
    output logic                          WR_READY,
    output logic [C_FIFO_DEPTH_WIDTH-1:0] WR_COUNT,
    output logic [C_DATA_WIDTH-1:0]       RD_DATA,
    output logic [2:0]                    RD_DW_VALID,
    output logic                          RD_EMPTY,
    input  logic                          RD_EN,
    output logic                          ERROR
);

    localparam int CW1 = C_FIFO_DEPTH_WIDTH + 1;

    rx_pack_state_t state_q, state_n;
    logic [95:0]    res_q, res_n, res_after;
    logic [1:0]     res_cnt_q, res_cnt_n, res_cnt_after;
    rx_word_t       stage_q, stage_n;
    logic           stage_vld_q, stage_vld_n;
    logic           ready_q;
    logic           error_q;

    logic [127:0]   wr_masked;
    logic [223:0]   combined;
    logic [2:0]     tot;
    logic           cnt_ok;
    logic           violation;
    logic           accept;
    logic           beat_acc;
    logic           done_acc;
    logic           full_word;

    logic [CW1-1:0] committed;
    logic           room_ok;
    logic           fifo_full;
    logic           fifo_empty;
    rx_word_t       head;

    assign WR_READY = ready_q && RST_N;

    // Words already owed to the FIFO (stored + staged) plus headroom for a flush and one more beat.
    assign committed = {1'b0, WR_COUNT} + CW1'(stage_vld_q) + CW1'(3);
    assign room_ok   = (committed <= CW1'(C_FIFO_DEPTH));

    always_comb begin
        wr_masked = '0;
        for (int i = 0; i < DWS_PER_WORD; i++) begin
            wr_masked[i*DW_WIDTH +: DW_WIDTH] =
                (i < int'(WR_DW_COUNT)) ? WR_DATA[i*DW_WIDTH +: DW_WIDTH] : '0;
        end
        combined = {128'b0, res_q} | ({96'b0, wr_masked} << {res_cnt_q, 5'b0});
        tot      = {1'b0, res_cnt_q} + WR_DW_COUNT;

        cnt_ok    = (WR_DW_COUNT != 3'd0) && (WR_DW_COUNT <= 3'd4);
        violation = (WR_EN && !cnt_ok) || ((WR_EN || WR_DONE) && !WR_READY);
        accept    = WR_READY && !violation;
        beat_acc  = accept && WR_EN;
        done_acc  = accept && WR_DONE;
        full_word = beat_acc && (tot >= 3'd4);

        res_after     = res_q;
        res_cnt_after = res_cnt_q;
        if (beat_acc) begin
            if (full_word) begin
                res_after     = combined[223:128];
                res_cnt_after = 2'(tot - 3'd4);
            end else begin
                res_after     = combined[95:0];
                res_cnt_after = tot[1:0];
            end
        end

        state_n      = state_q;
        stage_n.cnt  = 3'd4;
        stage_n.data = combined[127:0];
        stage_vld_n  = full_word;
        res_n        = res_after;
        res_cnt_n    = res_cnt_after;

        if (state_q == S_FLUSH) begin
            stage_n.cnt  = {1'b0, res_cnt_q};
            stage_n.data = {32'b0, res_q};
            stage_vld_n  = 1'b1;
            res_n        = '0;
            res_cnt_n    = '0;
            state_n      = S_PACK;
        end else if (done_acc && (res_cnt_after != 2'd0)) begin
            // A full word already claims the stage this cycle, so the partial word waits one cycle.
            if (full_word) begin
                state_n = S_FLUSH;
            end else begin
                stage_n.cnt  = {1'b0, res_cnt_after};
                stage_n.data = {32'b0, res_after};
                stage_vld_n  = 1'b1;
                res_n        = '0;
                res_cnt_n    = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= S_PACK;
            res_q       <= '0;
            res_cnt_q   <= '0;
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_n;
            res_q       <= res_n;
            res_cnt_q   <= res_cnt_n;
            stage_q     <= stage_n;
            stage_vld_q <= stage_vld_n;
            ready_q     <= (state_n == S_PACK) && room_ok && !fifo_full;
            error_q     <= error_q || violation;
        end
    end

    sync_fifo #(
        .C_WIDTH         ($bits(rx_word_t)),
        .C_DEPTH         (C_FIFO_DEPTH),
        .C_PROVIDE_COUNT (1)
    ) u_fifo (
        .clk    (CLK),
        .rst_n  (RST_N),
        .wr_dat (stage_q),
        .wr_vld (stage_vld_q),
        .full   (fifo_full),
        .rd_dat (head),
        .empty  (fifo_empty),
        .rd_rdy (RD_EN),
        .count  (WR_COUNT)
    );

    assign RD_EMPTY    = fifo_empty;
    assign RD_DATA     = fifo_empty ? '0 : head.data;
    assign RD_DW_VALID = fifo_empty ? 3'd0 : head.cnt;
    assign ERROR       = error_q;

endmodule

// File: doc/rx_port_packer_128.md
Name: rx_port_packer_128

Overview:
Receive-side counterpart of the channel TX buffer. Accepts DWORD-granular payload fragments of 1–4 DWORDs per beat, as produced by completion reordering, and packs them into full 128-bit words. At end of transfer it flushes any partial word. Packed words go into a FIFO, and the RX channel interface drains that FIFO, reading a valid-DWORD count with each word.

Parameters:
C_DATA_WIDTH, 128, data bus width (4 DWORDs); fixed at 128.
C_FIFO_DEPTH, 512, FIFO depth in words.
C_FIFO_DEPTH_WIDTH, clog2((2**clog2(C_FIFO_DEPTH))+1), width of WR_COUNT (local).

Ports:
CLK  in  1  clock; all logic is on the rising edge.
RST_N  in  1  reset, synchronous, active-low.
WR_DATA  in  128  input fragment; valid DWORDs packed from bit 0 upward.
WR_EN  in  1  fragment valid.
WR_DW_COUNT  in  3  DWORDs valid in WR_DATA; legal values 1..4.
WR_DONE  in  1  end of transfer; flush the residue after this beat's data.
WR_READY  out  1  upstream may assert WR_EN or WR_DONE only while this is 1.
WR_COUNT  out  C_FIFO_DEPTH_WIDTH  FIFO occupancy in words.
RD_DATA  out  128  head word of the FIFO (first-word-fall-through).
RD_DW_VALID  out  3  valid DWORDs in RD_DATA (1..4).
RD_EMPTY  out  1  FIFO empty.
RD_EN  in  1  pop the head word.
ERROR  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (RST_N=0 at an edge): residue empties, state becomes S_PACK, the write stage clears, the FIFO empties. Holds mid-transfer too; partial data is discarded.
- Output values during and after reset: WR_READY=0 during reset; RD_EMPTY=1, WR_COUNT=0, ERROR=0, RD_DW_VALID=0.
- Residue: rRes[95:0] and rResCnt[1:0], 0..3 DWORDs held.
- Accepted beat (WR_EN & WR_READY & 1<=WR_DW_COUNT<=4):
  - combined[223:0] = rRes | (WR_DATA << 32*rResCnt); tot = rResCnt + WR_DW_COUNT (0..7).
  - tot>=4: write stage loads {combined[127:0], cnt=4}; residue = combined[223:128], rResCnt = tot-4.
  - Otherwise: residue = combined, rResCnt = tot.
- WR_DONE semantics (accepted when WR_READY=1, with or without WR_EN):
  - Residue nonempty after the beat and the write stage is idle this cycle: load {residue, cnt=rResCnt}, zero-filled above the count; rResCnt=0.
  - Residue nonempty and the stage is already loaded with a full word: go to S_FLUSH; WR_READY=0 for exactly one cycle. In S_FLUSH, load the residue partial word, clear the residue, return to S_PACK.
  - Residue empty: no extra write.
- Write stage: a registered {data, cnt, valid} drives the FIFO write the next cycle. Beat at edge T → FIFO write at T+1 → RD_EMPTY=0 after edge T+2.
- WR_READY = (state==S_PACK) & RST_N & (free FIFO entries >= 3). The 3 entries cover the stage, the flush and one in-flight word. Registered; deasserts before overflow.
- Protocol violations: WR_EN with WR_DW_COUNT of 0 or 5..7, or WR_EN/WR_DONE while WR_READY=0. The beat is dropped, state is unchanged, ERROR sets and stays 1 until reset.
- Read side: FWFT. RD_DATA and RD_DW_VALID are valid whenever RD_EMPTY=0. RD_EN with RD_EMPTY=0 pops at the edge; RD_EN while empty is ignored.
- Simultaneous FIFO write and pop: WR_COUNT is unchanged. Full boundary: unreachable while the WR_READY rule holds.
- Zero-fill rule: DWORDs above RD_DW_VALID are 0.

Decomposition:
- Package rx_port_pkg:
  - localparams DW_WIDTH=32, DWS_PER_WORD=4.
  - typedef enum {S_PACK, S_FLUSH} rx_pack_state_t.
  - packed struct rx_word_t {logic [2:0] cnt; logic [127:0] data}.
- Sub-module: one instance of the codebase's sync_fifo in first-word-fall-through mode, C_WIDTH = 131 (rx_word_t), C_DEPTH = C_FIFO_DEPTH, C_PROVIDE_COUNT = 1.
- Packer, flush FSM and write stage stay in rx_port_packer_128.

Test Plan:
- Four beats of 4 DWORDs (0x0..0xF), then WR_DONE → 4 words, each RD_DW_VALID=4, data in order; RD_EMPTY falls 2 cycles after the first beat.
- Beats of 3,3,3,3 DWORDs (DW values 1..12) → 3 full words: [1..4], [5..8], [9..12]; residue 0; no flush write.
- Beats 2, 3 (DW values A..E) with WR_DONE on the second → full word [A..D], WR_READY low 1 cycle, then partial word [E,0,0,0] with RD_DW_VALID=1.
- Single 1-DWORD beat 0xDEADBEEF with WR_DONE → one word {0,0,0,0xDEADBEEF}, RD_DW_VALID=1, WR_READY never drops.
- Fill with no reads until WR_READY=0 → WR_READY falls at free space <3; a forced WR_EN then sets ERROR=1 and no data is lost; WR_DW_COUNT=0 also sets ERROR.
- Reset asserted with residue=2 and FIFO holding 5 words → after release: RD_EMPTY=1, WR_COUNT=0, ERROR=0; a new 4-DWORD beat emerges alone.
